aud_play_ctrl: RTL and testbench
================================

// Module: aud_play_ctrl
// PURPOSE
//  Playback sequencer for the audio output path. Fetches 16-bit samples from
//  sample memory over a req/ack port and presents one sample per LRCK frame to
//  the DAC serializer. Also drives the serializer enable.
//  Supports start/pause/resume/stop and a fast-forward step. Sits between the
//  top-level control FSM, the SRAM front-end and the serializer.
// PARAMETERS
//  ADDR_W   20   sample-memory word address width
// PORTS
//  i_bclk        in   1       audio bit clock; single clock, all logic posedge
//  i_rst         in   1       synchronous, active-high reset
//  i_start       in   1       1-cycle pulse: start from IDLE / resume from PAUSE
//  i_pause       in   1       1-cycle pulse: pause playback
//  i_stop        in   1       1-cycle pulse: abort, return to IDLE
//  i_speed       in   3       address step minus 1 (step = i_speed+1, 1..8)
//  i_start_addr  in   ADDR_W  first sample address, sampled on start from IDLE
//  i_end_addr    in   ADDR_W  last valid sample address (inclusive), sampled with start
//  i_daclrck     in   1       DAC LR clock; rising edge = new frame
//  o_mem_req     out  1       read request, held until i_mem_ack
//  o_mem_addr    out  ADDR_W  read address, stable while o_mem_req=1
//  i_mem_ack     in   1       1-cycle pulse; i_mem_rdata valid same cycle
//  i_mem_rdata   in   16      sample data
//  o_player_en   out  1       serializer enable
//  o_dac_data    out  16      sample to serializer, changes only at frame edge
//  o_busy        out  1       state != IDLE
//  o_done        out  1       1-cycle pulse at end of clip
//  o_underrun    out  1       1-cycle pulse: frame edge with no sample buffered
// BEHAVIOUR
//  Reset: state=S_IDLE; all outputs 0; addr=0; buffer=0; prev_lrck=0.
//  Frame edge: fe = i_daclrck & ~prev_lrck; prev_lrck is registered each cycle.
//  Command priority, same cycle: stop > pause > start.
//  States:
//   S_IDLE : i_start -> latch start/end addr, addr=start, go S_FETCH.
//   S_FETCH: o_mem_req=1, o_mem_addr=addr. On ack: buf=rdata, buf_vld=1,
//            nxt=addr+step (ADDR_W+1 bits, no wrap), go S_READY.
//            fe while in FETCH: o_underrun=1, o_dac_data holds its value.
//   S_READY: on fe: o_dac_data<=buf, buf_vld=0.
//            nxt>end -> S_DONE; else addr=nxt, -> S_FETCH.
//   S_PAUSE: o_player_en=0, o_dac_data=0, no requests.
//            i_start -> S_FETCH if !buf_vld, else S_READY.
//   S_DONE : o_done=1 for this cycle, o_dac_data=0; next cycle -> S_IDLE.
//  o_player_en=1 in S_FETCH/S_READY, else 0 (registered, 1 cycle after state).
//  Latency: start pulse -> o_mem_req high next cycle.
//   First sample reaches o_dac_data on the first fe after ack, same-cycle update.
//  Pause in S_FETCH with req pending: keep req until ack, store buf, then PAUSE.
//   Requests are never abandoned except by stop or reset.
//  Stop/reset mid-fetch: req drops next cycle; a late ack is ignored in IDLE.
//  i_start while busy (not PAUSE) ignored; i_pause in IDLE/DONE ignored.
//  i_speed sampled at each fetch, so a mid-clip change takes effect next step.
//  start_addr>end_addr: play the single sample at start_addr, then DONE.
//  Clip ending at end_addr=2^ADDR_W-1: the widened nxt must not wrap to 0.
// TESTING
//  1. start=0x10,end=0x13,speed=0, ack 2 cycles after req -> data 0x10..0x13
//     at 4 successive fe; o_done pulse once; o_busy falls next cycle.
//  2. speed=3, start=0,end=9 -> fetch addrs 0,4,8 only; DONE after 3rd fe.
//  3. pause while req pending, ack 5 cycles later -> req held to ack,
//     player_en=0, dac_data=0; start resumes with the buffered sample on next fe.
//  4. ack delayed past fe -> o_underrun 1 cycle; dac_data holds previous;
//     the late sample goes out on the following fe.
//  5. stop+pause+start same cycle mid-clip -> S_IDLE, req low next cycle; late ack
//     ignored. Reset mid-READY -> all outputs 0.
//  6. end_addr=0xFFFFF, start=0xFFFFE, speed=7 -> 0xFFFFE played, then DONE.
//     No wrap to address 0.

Source files
------------

// File: rtl/aud_play_ctrl.sv
// aud_play_ctrl: playback sequencer, fetches 16-bit samples over req/ack and emits one per LRCK frame.
// Latency: start -> o_mem_req next cycle; a fetched sample reaches o_dac_data on the first frame edge after ack.
// Backpressure: o_mem_req is held until i_mem_ack; a frame edge with no sample buffered pulses o_underrun.
//
// Ports:
//   i_bclk / i_rst             bit clock, synchronous active-high reset
//   i_start/i_pause/i_stop     1-cycle command pulses (priority stop > pause > start)
//   i_speed                    address step minus 1
//   i_start_addr/i_end_addr    clip bounds (end inclusive), captured on start from idle
//   i_daclrck                  LR clock, rising edge marks a new frame
//   o_mem_req/o_mem_addr       sample read request, i_mem_ack/i_mem_rdata response
//   o_player_en/o_dac_data     serializer enable and sample
//   o_busy/o_done/o_underrun   status

module aud_play_ctrl #(
    parameter int ADDR_W = 20
) (
    input  logic              i_bclk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic [2:0]        i_speed,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic [ADDR_W-1:0] i_end_addr,
    input  logic              i_daclrck,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic [15:0]       i_mem_rdata,
    output logic              o_player_en,
    output logic [15:0]       o_dac_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_READY,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_end;
    // One bit wider than the address so a clip ending at the top of memory
    // compares as "past the end" instead of wrapping back to address 0.
    logic [ADDR_W:0]     r_nxt;
    logic [15:0]         r_buf;
    logic                r_buf_vld;
    logic                r_prev_lrck;
    logic                r_pause_pend;
    logic                r_player_en;
    logic [15:0]         r_dac_data;

    logic                w_fe;
    logic                w_past_end;
    logic [ADDR_W:0]     w_step;

    assign w_fe       = i_daclrck & ~r_prev_lrck;
    assign w_past_end = (r_nxt > {1'b0, r_end});
    assign w_step     = {{(ADDR_W-2){1'b0}}, i_speed} + {{ADDR_W{1'b0}}, 1'b1};

    // State register
    always_ff @(posedge i_bclk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and combinational outputs
    always_comb begin
        w_state_nxt = r_state;
        o_mem_req   = 1'b0;
        o_done      = 1'b0;
        o_underrun  = 1'b0;
        o_busy      = (r_state != S_IDLE);
        o_mem_addr  = r_addr;
        o_player_en = r_player_en;
        o_dac_data  = r_dac_data;

        case (r_state)
            S_IDLE: begin
                if (!i_stop && i_start) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                o_mem_req = 1'b1;
                // While a pause is pending playback is already frozen, so a
                // frame edge is not reported as an underrun.
                o_underrun = w_fe & ~r_pause_pend;
                if (i_stop) begin
                    w_state_nxt = S_IDLE;
                end else if (i_mem_ack) begin
                    // A pause never abandons an outstanding request: the
                    // sample is buffered first, then the pause takes effect.
                    w_state_nxt = (r_pause_pend || i_pause) ? S_PAUSE : S_READY;
                end
            end
            S_READY: begin
                if (i_stop) begin
                    w_state_nxt = S_IDLE;
                end else if (i_pause) begin
                    w_state_nxt = S_PAUSE;
                end else if (w_fe) begin
                    w_state_nxt = w_past_end ? S_DONE : S_FETCH;
                end
            end
            S_PAUSE: begin
                if (i_stop) begin
                    w_state_nxt = S_IDLE;
                end else if (!i_pause && i_start) begin
                    w_state_nxt = r_buf_vld ? S_READY : S_FETCH;
                end
            end
            S_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath
    always_ff @(posedge i_bclk) begin
        if (i_rst) begin
            r_addr       <= '0;
            r_end        <= '0;
            r_nxt        <= '0;
            r_buf        <= '0;
            r_buf_vld    <= 1'b0;
            r_prev_lrck  <= 1'b0;
            r_pause_pend <= 1'b0;
            r_player_en  <= 1'b0;
            r_dac_data   <= '0;
        end else begin
            r_prev_lrck <= i_daclrck;
            r_player_en <= ((r_state == S_FETCH) && !r_pause_pend) || (r_state == S_READY);

            if (i_stop) begin
                r_buf_vld    <= 1'b0;
                r_pause_pend <= 1'b0;
                r_dac_data   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_addr       <= i_start_addr;
                            r_end        <= i_end_addr;
                            r_buf_vld    <= 1'b0;
                            r_pause_pend <= 1'b0;
                        end
                    end
                    S_FETCH: begin
                        if (i_mem_ack) begin
                            r_buf        <= i_mem_rdata;
                            r_buf_vld    <= 1'b1;
                            // Step is taken at fetch time so a speed change
                            // applies from the next address onward.
                            r_nxt        <= {1'b0, r_addr} + w_step;
                            r_pause_pend <= 1'b0;
                        end else if (i_pause) begin
                            r_pause_pend <= 1'b1;
                        end
                    end
                    S_READY: begin
                        if (!i_pause && w_fe) begin
                            r_dac_data <= r_buf;
                            r_buf_vld  <= 1'b0;
                            if (!w_past_end) begin
                                r_addr <= r_nxt[ADDR_W-1:0];
                            end
                        end
                    end
                    S_PAUSE, S_DONE: begin
                        r_dac_data <= '0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aud_play_ctrl.sv
// tb_aud_play_ctrl: directed bench for the playback sequencer.
// Latency: memory responder acks a programmable number of cycles after o_mem_req rises.
// Backpressure: ack delay and LRCK edges are driven per scenario to hit stall/underrun/pause paths.

module tb_aud_play_ctrl;

    localparam int ADDR_W = 20;

    logic              i_bclk = 1'b0;
    logic              i_rst;
    logic              i_start;
    logic              i_pause;
    logic              i_stop;
    logic [2:0]        i_speed;
    logic [ADDR_W-1:0] i_start_addr;
    logic [ADDR_W-1:0] i_end_addr;
    logic              i_daclrck;
    logic              o_mem_req;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              i_mem_ack;
    logic [15:0]       i_mem_rdata;
    logic              o_player_en;
    logic [15:0]       o_dac_data;
    logic              o_busy;
    logic              o_done;
    logic              o_underrun;

    int checks = 0;
    int errors = 0;
    int ack_dly = 2;
    int mem_cnt = 0;
    bit force_ack = 1'b0;

    aud_play_ctrl #(.ADDR_W(ADDR_W)) dut (
        .i_bclk       (i_bclk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_pause      (i_pause),
        .i_stop       (i_stop),
        .i_speed      (i_speed),
        .i_start_addr (i_start_addr),
        .i_end_addr   (i_end_addr),
        .i_daclrck    (i_daclrck),
        .o_mem_req    (o_mem_req),
        .o_mem_addr   (o_mem_addr),
        .i_mem_ack    (i_mem_ack),
        .i_mem_rdata  (i_mem_rdata),
        .o_player_en  (o_player_en),
        .o_dac_data   (o_dac_data),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_underrun   (o_underrun)
    );

    always #5 i_bclk = ~i_bclk;

    // Sample memory: word at address a is {4'hD, a[11:0]}.
    function automatic logic [15:0] mem_word(input logic [ADDR_W-1:0] a);
        return {4'hD, a[11:0]};
    endfunction

    // Memory responder: ack arrives ack_dly cycles after the request is first seen.
    initial begin
        i_mem_ack   = 1'b0;
        i_mem_rdata = '0;
        forever begin
            @(posedge i_bclk);
            #1;
            i_mem_ack = 1'b0;
            if (force_ack) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = 16'hBAD0;
                force_ack   = 1'b0;
                mem_cnt     = 0;
            end else if (o_mem_req) begin
                if (mem_cnt == ack_dly) begin
                    i_mem_ack   = 1'b1;
                    i_mem_rdata = mem_word(o_mem_addr);
                    mem_cnt     = 0;
                end else begin
                    mem_cnt++;
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge i_bclk);
        #1;
    endtask

    // Advance until the sequencer sits in READY (busy, no request); bounded.
    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (!o_mem_req && o_busy) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic chk_wait(input bit ok, input string name);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: timed out waiting for READY", name);
        end
    endtask

    task automatic frame_edge();
        i_daclrck = 1'b1;
        tick();
        i_daclrck = 1'b0;
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] ea,
                               input logic [2:0] spd);
        i_start_addr = sa;
        i_end_addr   = ea;
        i_speed      = spd;
        i_start      = 1'b1;
        tick();
        i_start      = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) tick();
        @(negedge i_bclk);
        checks++;
        if ({o_mem_req, o_player_en, o_busy, o_done, o_underrun} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {o_mem_req, o_player_en, o_busy, o_done, o_underrun});
        end
        checks++;
        if (o_mem_addr !== '0) begin
            errors++;
            $display("FAIL reset_addr: got %h expected 00000", o_mem_addr);
        end
        checks++;
        if (o_dac_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_dac: got %h expected 0000", o_dac_data);
        end
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        logic [15:0] exp_prev;
        logic [15:0] exp;
        ack_dly = 2;
        pulse_start(20'h00010, 20'h00013, 3'd0);
        @(negedge i_bclk);
        checks++;
        if ({o_mem_req, o_mem_addr} !== {1'b1, 20'h00010}) begin
            errors++;
            $display("FAIL basic_req_latency: got req=%b addr=%h expected req=1 addr=00010",
                     o_mem_req, o_mem_addr);
        end
        exp_prev = 16'h0;
        for (int s = 0; s < 4; s++) begin
            wait_ready(ok);
            chk_wait(ok, "basic_wait");
            if (s == 0) begin
                checks++;
                if (o_player_en !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_player_en: got %b expected 1", o_player_en);
                end
            end
            i_daclrck = 1'b1;
            @(negedge i_bclk);
            checks++;
            if ({o_dac_data, o_underrun} !== {exp_prev, 1'b0}) begin
                errors++;
                $display("FAIL basic_hold[%0d]: got dac=%h und=%b expected dac=%h und=0",
                         s, o_dac_data, o_underrun, exp_prev);
            end
            tick();
            i_daclrck = 1'b0;
            @(negedge i_bclk);
            exp = 16'hD010 + 16'(s);
            checks++;
            if (o_dac_data !== exp) begin
                errors++;
                $display("FAIL basic_sample[%0d]: got %h expected %h", s, o_dac_data, exp);
            end
            checks++;
            if (o_done !== (s == 3)) begin
                errors++;
                $display("FAIL basic_done[%0d]: got %b expected %b", s, o_done, (s == 3));
            end
            exp_prev = exp;
        end
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_in_done: got %b expected 1", o_busy);
        end
        tick();
        @(negedge i_bclk);
        checks++;
        if ({o_done, o_busy, o_dac_data} !== {2'b00, 16'h0}) begin
            errors++;
            $display("FAIL basic_after_done: got done=%b busy=%b dac=%h expected 0 0 0000",
                     o_done, o_busy, o_dac_data);
        end
    endtask

    task automatic test_speed();
        bit ok;
        logic [ADDR_W-1:0] exp_addr;
        logic [15:0] exp;
        ack_dly = 1;
        pulse_start(20'h00000, 20'h00009, 3'd3);
        for (int k = 0; k < 3; k++) begin
            exp_addr = ADDR_W'(4 * k);
            checks++;
            if ({o_mem_req, o_mem_addr} !== {1'b1, exp_addr}) begin
                errors++;
                $display("FAIL speed_addr[%0d]: got req=%b addr=%h expected req=1 addr=%h",
                         k, o_mem_req, o_mem_addr, exp_addr);
            end
            wait_ready(ok);
            chk_wait(ok, "speed_wait");
            frame_edge();
            @(negedge i_bclk);
            exp = 16'hD000 + 16'(4 * k);
            checks++;
            if (o_dac_data !== exp) begin
                errors++;
                $display("FAIL speed_sample[%0d]: got %h expected %h", k, o_dac_data, exp);
            end
        end
        checks++;
        if ({o_done, o_mem_req} !== 2'b10) begin
            errors++;
            $display("FAIL speed_done: got done=%b req=%b expected done=1 req=0", o_done, o_mem_req);
        end
        tick();
        @(negedge i_bclk);
        checks++;
        if ({o_busy, o_mem_req} !== 2'b00) begin
            errors++;
            $display("FAIL speed_idle: got busy=%b req=%b expected 0 0", o_busy, o_mem_req);
        end
    endtask

    task automatic test_pause();
        bit ok;
        int n;
        ack_dly = 5;
        pulse_start(20'h00020, 20'h0002F, 3'd0);
        wait_ready(ok);
        chk_wait(ok, "pause_wait");
        frame_edge();
        // Now fetching 0x21 with the request freshly raised.
        i_pause = 1'b1;
        tick();
        i_pause = 1'b0;
        n = 0;
        while (o_mem_req && n < 20) begin
            n++;
            if (n == 2) begin
                @(negedge i_bclk);
                checks++;
                if (o_player_en !== 1'b0) begin
                    errors++;
                    $display("FAIL pause_en_pending: got %b expected 0", o_player_en);
                end
            end
            tick();
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL pause_req_held: got %0d cycles expected 5", n);
        end
        @(negedge i_bclk);
        checks++;
        if ({o_mem_req, o_busy, o_player_en} !== 3'b010) begin
            errors++;
            $display("FAIL pause_state: got req=%b busy=%b en=%b expected 0 1 0",
                     o_mem_req, o_busy, o_player_en);
        end
        i_daclrck = 1'b1;
        #1;
        checks++;
        if (o_underrun !== 1'b0) begin
            errors++;
            $display("FAIL pause_underrun: got %b expected 0", o_underrun);
        end
        tick();
        i_daclrck = 1'b0;
        tick();
        @(negedge i_bclk);
        checks++;
        if (o_dac_data !== 16'h0) begin
            errors++;
            $display("FAIL pause_dac: got %h expected 0000", o_dac_data);
        end
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        frame_edge();
        @(negedge i_bclk);
        checks++;
        if (o_dac_data !== 16'hD021) begin
            errors++;
            $display("FAIL pause_resume: got %h expected D021", o_dac_data);
        end
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        tick();
    endtask

    task automatic test_underrun();
        bit ok;
        ack_dly = 6;
        pulse_start(20'h00030, 20'h0003F, 3'd0);
        wait_ready(ok);
        chk_wait(ok, "underrun_wait");
        frame_edge();
        tick();
        i_daclrck = 1'b1;
        @(negedge i_bclk);
        checks++;
        if ({o_underrun, o_dac_data} !== {1'b1, 16'hD030}) begin
            errors++;
            $display("FAIL underrun_pulse: got und=%b dac=%h expected und=1 dac=D030",
                     o_underrun, o_dac_data);
        end
        tick();
        i_daclrck = 1'b0;
        @(negedge i_bclk);
        checks++;
        if ({o_underrun, o_dac_data} !== {1'b0, 16'hD030}) begin
            errors++;
            $display("FAIL underrun_one_cycle: got und=%b dac=%h expected und=0 dac=D030",
                     o_underrun, o_dac_data);
        end
        wait_ready(ok);
        chk_wait(ok, "underrun_wait2");
        frame_edge();
        @(negedge i_bclk);
        checks++;
        if (o_dac_data !== 16'hD031) begin
            errors++;
            $display("FAIL underrun_late_sample: got %h expected D031", o_dac_data);
        end
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        tick();
    endtask

    task automatic test_stop_reset();
        bit ok;
        ack_dly = 10;
        pulse_start(20'h00040, 20'h0004F, 3'd0);
        tick();
        tick();
        i_stop  = 1'b1;
        i_pause = 1'b1;
        i_start = 1'b1;
        tick();
        i_stop  = 1'b0;
        i_pause = 1'b0;
        i_start = 1'b0;
        @(negedge i_bclk);
        checks++;
        if ({o_mem_req, o_busy} !== 2'b00) begin
            errors++;
            $display("FAIL stop_priority: got req=%b busy=%b expected 0 0", o_mem_req, o_busy);
        end
        force_ack = 1'b1;
        tick();
        tick();
        @(negedge i_bclk);
        checks++;
        if ({o_mem_req, o_busy, o_player_en} !== 3'b000) begin
            errors++;
            $display("FAIL stop_late_ack: got req=%b busy=%b en=%b expected 0 0 0",
                     o_mem_req, o_busy, o_player_en);
        end
        ack_dly = 1;
        pulse_start(20'h00050, 20'h0005F, 3'd0);
        wait_ready(ok);
        chk_wait(ok, "reset_wait");
        frame_edge();
        wait_ready(ok);
        chk_wait(ok, "reset_wait2");
        @(negedge i_bclk);
        checks++;
        if ({o_dac_data, o_player_en} !== {16'hD050, 1'b1}) begin
            errors++;
            $display("FAIL reset_precond: got dac=%h en=%b expected D050 1", o_dac_data, o_player_en);
        end
        i_rst = 1'b1;
        tick();
        @(negedge i_bclk);
        checks++;
        if ({o_mem_req, o_player_en, o_busy, o_done, o_underrun, o_dac_data, o_mem_addr} !==
            {5'b0, 16'h0, 20'h0}) begin
            errors++;
            $display("FAIL reset_mid_ready: got req=%b en=%b busy=%b done=%b und=%b dac=%h addr=%h expected all 0",
                     o_mem_req, o_player_en, o_busy, o_done, o_underrun, o_dac_data, o_mem_addr);
        end
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_top_addr();
        bit ok;
        ack_dly = 1;
        pulse_start(20'hFFFFE, 20'hFFFFF, 3'd7);
        checks++;
        if ({o_mem_req, o_mem_addr} !== {1'b1, 20'hFFFFE}) begin
            errors++;
            $display("FAIL top_addr_req: got req=%b addr=%h expected 1 FFFFE", o_mem_req, o_mem_addr);
        end
        wait_ready(ok);
        chk_wait(ok, "top_wait");
        frame_edge();
        @(negedge i_bclk);
        checks++;
        if ({o_dac_data, o_done, o_mem_req} !== {16'hDFFE, 2'b10}) begin
            errors++;
            $display("FAIL top_addr_done: got dac=%h done=%b req=%b expected DFFE 1 0",
                     o_dac_data, o_done, o_mem_req);
        end
        repeat (3) tick();
        @(negedge i_bclk);
        checks++;
        if ({o_busy, o_mem_req} !== 2'b00) begin
            errors++;
            $display("FAIL top_addr_no_wrap: got busy=%b req=%b expected 0 0", o_busy, o_mem_req);
        end
        // Last address of memory with unit step.
        pulse_start(20'hFFFFF, 20'hFFFFF, 3'd0);
        wait_ready(ok);
        chk_wait(ok, "top_wait2");
        frame_edge();
        @(negedge i_bclk);
        checks++;
        if ({o_dac_data, o_done, o_mem_req} !== {16'hDFFF, 2'b10}) begin
            errors++;
            $display("FAIL top_last_word: got dac=%h done=%b req=%b expected DFFF 1 0",
                     o_dac_data, o_done, o_mem_req);
        end
        tick();
    endtask

    task automatic test_start_gt_end();
        bit ok;
        ack_dly = 0;
        pulse_start(20'h00060, 20'h00050, 3'd0);
        wait_ready(ok);
        chk_wait(ok, "sge_wait");
        frame_edge();
        @(negedge i_bclk);
        checks++;
        if ({o_dac_data, o_done} !== {16'hD060, 1'b1}) begin
            errors++;
            $display("FAIL start_gt_end: got dac=%h done=%b expected D060 1", o_dac_data, o_done);
        end
        tick();
        @(negedge i_bclk);
        checks++;
        if ({o_busy, o_mem_req} !== 2'b00) begin
            errors++;
            $display("FAIL start_gt_end_idle: got busy=%b req=%b expected 0 0", o_busy, o_mem_req);
        end
    endtask

    initial begin
        i_rst        = 1'b1;
        i_start      = 1'b0;
        i_pause      = 1'b0;
        i_stop       = 1'b0;
        i_speed      = 3'd0;
        i_start_addr = '0;
        i_end_addr   = '0;
        i_daclrck    = 1'b0;
        test_reset();
        test_basic();
        test_speed();
        test_pause();
        test_underrun();
        test_stop_reset();
        test_top_addr();
        test_start_gt_end();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
